// File: rtl/jtag_pkg.sv
// Shared TAP definitions: standard 4-bit state encodings, opcode values,
// DR-select enum and the TMS next-state function.
package jtag_pkg;

    typedef enum logic [3:0] {
        EX2_DR = 4'h0, EX1_DR = 4'h1, SHF_DR = 4'h2, PAU_DR = 4'h3,
        SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
        EX2_IR = 4'h8, EX1_IR = 4'h9, SHF_IR = 4'hA, PAU_IR = 4'hB,
        RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BSR,
        DR_BYPASS,
        DR_IDCODE
    } dr_sel_e;

    // Opcode values; the top sizes them to its IR_WIDTH (BYPASS is all ones).
    localparam int OPC_EXTEST = 0;
    localparam int OPC_SAMPLE = 1;
    localparam int OPC_IDCODE = 2;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        n = TLR;
        case (s)
            TLR:     n = tms ? TLR    : RTI;
            RTI:     n = tms ? SEL_DR : RTI;
            SEL_DR:  n = tms ? SEL_IR : CAP_DR;
            CAP_DR:  n = tms ? EX1_DR : SHF_DR;
            SHF_DR:  n = tms ? EX1_DR : SHF_DR;
            EX1_DR:  n = tms ? UPD_DR : PAU_DR;
            PAU_DR:  n = tms ? EX2_DR : PAU_DR;
            EX2_DR:  n = tms ? UPD_DR : SHF_DR;
            UPD_DR:  n = tms ? SEL_DR : RTI;
            SEL_IR:  n = tms ? TLR    : CAP_IR;
            CAP_IR:  n = tms ? EX1_IR : SHF_IR;
            SHF_IR:  n = tms ? EX1_IR : SHF_IR;
            EX1_IR:  n = tms ? UPD_IR : PAU_IR;
            PAU_IR:  n = tms ? EX2_IR : PAU_IR;
            EX2_IR:  n = tms ? UPD_IR : SHF_IR;
            UPD_IR:  n = tms ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP state register: one TMS-driven transition per tck_en strobe.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       ICLK,
    input  logic       IRSTn,
    input  logic       tck_en,
    input  logic       TMS,
    output tap_state_e state
);

    always_ff @(posedge ICLK or negedge IRSTn) begin
        if (!IRSTn) begin
            state <= TLR;
        end else if (tck_en) begin
            state <= tap_next(state, TMS);
        end
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// Boundary-scan TAP controller: IR/BYPASS/IDCODE registers, TDO mux and scan-cell strobes.
// Define JTAG_IDCODE_EN to include the IDCODE register and make it the reset instruction.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH = 4,
    parameter logic [31:0] IDCODE   = 32'h1234_5677
) (
    input  logic       ICLK,
    input  logic       IRSTn,
    input  logic       tck_en,
    input  logic       TMS,
    input  logic       TDI,
    output logic       TDO,
    output logic       tdo_oe,
    output logic       bsr_si,
    input  logic       bsr_so,
    output logic       mode,
    output logic       shift_dr,
    output logic       clk_dr,
    output logic       update_dr,
    output logic [3:0] tap_state
);

    localparam logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(OPC_EXTEST);
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(OPC_SAMPLE);
    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(OPC_IDCODE);
    localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_RESET  = OP_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET  = OP_BYPASS;
`endif

    tap_state_e          state;
    tap_state_e          state_nxt;
    dr_sel_e             dr_sel;
    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] ir_sh;
    logic                bypass_q;
    logic                idcode_lsb;
    logic                dr_lsb;
    logic                bsr_sel;

    jtag_tap_fsm u_fsm (
        .ICLK   (ICLK),
        .IRSTn  (IRSTn),
        .tck_en (tck_en),
        .TMS    (TMS),
        .state  (state)
    );

    assign state_nxt = tap_next(state, TMS);
    assign tap_state = state;

    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir == OP_EXTEST || ir == OP_SAMPLE) begin
            dr_sel = DR_BSR;
        end
`ifdef JTAG_IDCODE_EN
        else if (ir == OP_IDCODE) begin
            dr_sel = DR_IDCODE;
        end
`endif
    end

    assign bsr_sel = (dr_sel == DR_BSR);

    // Scan-cell controls are combinational so the cells act on the same ICLK edge as the TAP.
    assign bsr_si    = TDI;
    assign shift_dr  = bsr_sel && (state == SHF_DR);
    assign clk_dr    = tck_en && bsr_sel && (state == CAP_DR || state == SHF_DR);
    assign update_dr = tck_en && bsr_sel && (state == UPD_DR);

`ifdef JTAG_IDCODE_EN
    logic [31:0] idcode_sh;

    always_ff @(posedge ICLK or negedge IRSTn) begin
        if (!IRSTn) begin
            idcode_sh <= '0;
        end else if (tck_en) begin
            if (state == CAP_DR) begin
                idcode_sh <= IDCODE;
            end else if (state == SHF_DR) begin
                idcode_sh <= {TDI, idcode_sh[31:1]};
            end
        end
    end

    assign idcode_lsb = idcode_sh[0];
`else
    // DR_IDCODE is never decoded in this build, so this arm of the mux is unreachable.
    assign idcode_lsb = IDCODE[0];
`endif

    always_comb begin
        dr_lsb = bypass_q;
        case (dr_sel)
            DR_BSR:    dr_lsb = bsr_so;
            DR_IDCODE: dr_lsb = idcode_lsb;
            default:   dr_lsb = bypass_q;
        endcase
    end

    always_ff @(posedge ICLK or negedge IRSTn) begin
        if (!IRSTn) begin
            ir       <= IR_RESET;
            ir_sh    <= '0;
            bypass_q <= 1'b0;
            mode     <= 1'b0;
            TDO      <= 1'b0;
            tdo_oe   <= 1'b0;
        end else if (tck_en) begin
            case (state)
                CAP_DR:  bypass_q <= 1'b0;
                SHF_DR:  bypass_q <= TDI;
                CAP_IR:  ir_sh    <= IR_WIDTH'(2'b01);
                SHF_IR:  ir_sh    <= {TDI, ir_sh[IR_WIDTH-1:1]};
                default: ;
            endcase

            // Entering TLR wins; UPD_IR can never move directly to TLR anyway.
            if (state_nxt == TLR) begin
                ir   <= IR_RESET;
                mode <= 1'b0;
            end else if (state == UPD_IR) begin
                ir   <= ir_sh;
                mode <= (ir_sh == OP_EXTEST);
            end

            if (state == SHF_IR) begin
                TDO <= ir_sh[0];
            end else if (state == SHF_DR) begin
                TDO <= dr_lsb;
            end
            tdo_oe <= (state_nxt == SHF_DR || state_nxt == SHF_IR);
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Randomized and directed bench for jtag_tap_ctrl with a cycle-level reference model
// and an 8-cell scan chain attached to the scan-cell strobes.
module tb_jtag_tap_ctrl;

    localparam logic [31:0] IDC = 32'h1234_5677;
`ifdef JTAG_IDCODE_EN
    localparam bit IDC_EN = 1'b1;
`else
    localparam bit IDC_EN = 1'b0;
`endif
    localparam logic [3:0] RST_IR = IDC_EN ? 4'b0010 : 4'b1111;

    localparam logic [3:0] S_EX2DR = 4'h0, S_EX1DR = 4'h1, S_SHFDR = 4'h2, S_PAUDR = 4'h3;
    localparam logic [3:0] S_SELIR = 4'h4, S_UPDDR = 4'h5, S_CAPDR = 4'h6, S_SELDR = 4'h7;
    localparam logic [3:0] S_EX2IR = 4'h8, S_EX1IR = 4'h9, S_SHFIR = 4'hA, S_PAUIR = 4'hB;
    localparam logic [3:0] S_RTI   = 4'hC, S_UPDIR = 4'hD, S_CAPIR = 4'hE, S_TLR   = 4'hF;

    logic       ICLK   = 1'b0;
    logic       IRSTn  = 1'b0;
    logic       tck_en = 1'b0;
    logic       TMS    = 1'b0;
    logic       TDI    = 1'b0;
    logic       TDO, tdo_oe, bsr_si, bsr_so, mode, shift_dr, clk_dr, update_dr;
    logic [3:0] tap_state;

    logic [7:0] env_chain = 8'h00;
    logic [7:0] pins      = 8'hA5;

    int checks   = 0;
    int failures = 0;
    int n_cap_clk = 0, n_shf_clk = 0, n_upd = 0;

    logic [3:0]  nx0 [0:15];
    logic [3:0]  nx1 [0:15];
    logic [3:0]  m_st, m_ir, m_irsh;
    logic        m_mode, m_tdo, m_oe, m_byp;
    logic [31:0] m_idc;
    logic [7:0]  m_chain = 8'h00;

    jtag_tap_ctrl #(.IR_WIDTH(4), .IDCODE(IDC)) dut (
        .ICLK      (ICLK),
        .IRSTn     (IRSTn),
        .tck_en    (tck_en),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO),
        .tdo_oe    (tdo_oe),
        .bsr_si    (bsr_si),
        .bsr_so    (bsr_so),
        .mode      (mode),
        .shift_dr  (shift_dr),
        .clk_dr    (clk_dr),
        .update_dr (update_dr),
        .tap_state (tap_state)
    );

    always #5 ICLK = ~ICLK;

    // Scan cells: no reset, capture pins when shift_dr=0, shift toward bsr_so otherwise.
    always @(posedge ICLK) begin
        if (clk_dr) env_chain <= shift_dr ? {bsr_si, env_chain[7:1]} : pins;
    end
    assign bsr_so = env_chain[0];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic init_tbl();
        nx0[S_TLR]   = S_RTI;   nx1[S_TLR]   = S_TLR;
        nx0[S_RTI]   = S_RTI;   nx1[S_RTI]   = S_SELDR;
        nx0[S_SELDR] = S_CAPDR; nx1[S_SELDR] = S_SELIR;
        nx0[S_CAPDR] = S_SHFDR; nx1[S_CAPDR] = S_EX1DR;
        nx0[S_SHFDR] = S_SHFDR; nx1[S_SHFDR] = S_EX1DR;
        nx0[S_EX1DR] = S_PAUDR; nx1[S_EX1DR] = S_UPDDR;
        nx0[S_PAUDR] = S_PAUDR; nx1[S_PAUDR] = S_EX2DR;
        nx0[S_EX2DR] = S_SHFDR; nx1[S_EX2DR] = S_UPDDR;
        nx0[S_UPDDR] = S_RTI;   nx1[S_UPDDR] = S_SELDR;
        nx0[S_SELIR] = S_CAPIR; nx1[S_SELIR] = S_TLR;
        nx0[S_CAPIR] = S_SHFIR; nx1[S_CAPIR] = S_EX1IR;
        nx0[S_SHFIR] = S_SHFIR; nx1[S_SHFIR] = S_EX1IR;
        nx0[S_EX1IR] = S_PAUIR; nx1[S_EX1IR] = S_UPDIR;
        nx0[S_PAUIR] = S_PAUIR; nx1[S_PAUIR] = S_EX2IR;
        nx0[S_EX2IR] = S_SHFIR; nx1[S_EX2IR] = S_UPDIR;
        nx0[S_UPDIR] = S_RTI;   nx1[S_UPDIR] = S_SELDR;
    endtask

    // 0 = boundary-scan chain, 1 = bypass, 2 = idcode
    function automatic int m_dr(input logic [3:0] ir);
        if (ir == 4'd0 || ir == 4'd1) return 0;
        if (IDC_EN && ir == 4'd2) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        m_st = S_TLR; m_ir = RST_IR; m_irsh = 4'd0; m_mode = 1'b0;
        m_tdo = 1'b0; m_oe = 1'b0; m_byp = 1'b0; m_idc = 32'd0;
    endtask

    task automatic model_step(input logic tms, input logic tdi);
        logic [3:0] nxt;
        int dr;
        nxt = tms ? nx1[m_st] : nx0[m_st];
        dr  = m_dr(m_ir);
        if (m_st == S_SHFIR) m_tdo = m_irsh[0];
        else if (m_st == S_SHFDR) m_tdo = (dr == 0) ? m_chain[0] : (dr == 2) ? m_idc[0] : m_byp;
        m_oe = (nxt == S_SHFDR || nxt == S_SHFIR);
        if (m_st == S_CAPDR) begin
            m_byp = 1'b0; m_idc = IDC;
            if (dr == 0) m_chain = pins;
        end
        if (m_st == S_SHFDR) begin
            m_byp = tdi; m_idc = {tdi, m_idc[31:1]};
            if (dr == 0) m_chain = {tdi, m_chain[7:1]};
        end
        if (m_st == S_CAPIR) m_irsh = 4'b0001;
        if (m_st == S_SHFIR) m_irsh = {tdi, m_irsh[3:1]};
        if (nxt == S_TLR) begin
            m_ir = RST_IR; m_mode = 1'b0;
        end else if (m_st == S_UPDIR) begin
            m_ir = m_irsh; m_mode = (m_irsh == 4'd0);
        end
        m_st = nxt;
    endtask

    task automatic compare();
        int  dr;
        logic bsr;
        dr  = m_dr(m_ir);
        bsr = (dr == 0);
        chk("tap_state", 32'(tap_state), 32'(m_st));
        chk("TDO",       32'(TDO),       32'(m_tdo));
        chk("tdo_oe",    32'(tdo_oe),    32'(m_oe));
        chk("mode",      32'(mode),      32'(m_mode));
        chk("bsr_si",    32'(bsr_si),    32'(TDI));
        chk("shift_dr",  32'(shift_dr),  32'(bsr && m_st == S_SHFDR));
        chk("clk_dr",    32'(clk_dr),    32'(tck_en && IRSTn && bsr && (m_st == S_CAPDR || m_st == S_SHFDR)));
        chk("update_dr", 32'(update_dr), 32'(tck_en && IRSTn && bsr && m_st == S_UPDDR));
    endtask

    task automatic cyc(input logic te, input logic tms, input logic tdi);
        @(negedge ICLK);
        IRSTn = 1'b1; tck_en = te; TMS = tms; TDI = tdi; pins = 8'($urandom);
        #1;
        compare();
        if (clk_dr && !shift_dr) n_cap_clk++;
        if (clk_dr && shift_dr)  n_shf_clk++;
        if (update_dr)           n_upd++;
        if (te) model_step(tms, tdi);
    endtask

    task automatic rst_cyc(input logic te, input logic tms);
        @(negedge ICLK);
        IRSTn = 1'b0; tck_en = te; TMS = tms; TDI = 1'($urandom);
        #1;
        model_reset();
        compare();
    endtask

    task automatic strobe(input logic tms, input logic tdi);
        repeat ($urandom_range(0, 2)) cyc(1'b0, 1'($urandom), 1'($urandom));
        cyc(1'b1, tms, tdi);
    endtask

    task automatic strobe_rd(input logic tms, input logic tdi, output logic o);
        strobe(tms, tdi);
        @(posedge ICLK);
        #1;
        o = TDO;
    endtask

    task automatic goto_tlr();
        repeat (5) strobe(1'b1, 1'($urandom));
    endtask

    // From RTI: shift v into IR and stop in UPD_IR (the caller issues the update strobe).
    task automatic load_ir(input logic [3:0] v, output logic [3:0] cap);
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) strobe_rd(i == 3, v[i], cap[i]);
        strobe(1'b1, 1'b0);
    endtask

    task automatic rti_to_shf_dr();
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] word;
        logic [3:0]  cap;
        logic [4:0]  bout;
        logic [3:0]  byp_ops [2];
        logic        o;

        init_tbl();
        model_reset();
        rst_cyc(1'b1, 1'b1);
        rst_cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // Reset values
        chk("rst_state", 32'(tap_state), 32'h0000_000F);
        chk("rst_tdo",   32'(TDO),       32'd0);
        chk("rst_mode",  32'(mode),      32'd0);
        chk("rst_oe",    32'(tdo_oe),    32'd0);

        // Five TMS=1 strobes from SHF_DR reach TLR
        strobe(1'b0, 1'b0);
        rti_to_shf_dr();
        @(posedge ICLK); #1;
        chk("in_shf_dr", 32'(tap_state), 32'h0000_0002);
        goto_tlr();
        @(posedge ICLK); #1;
        chk("tlr_state", 32'(tap_state), 32'h0000_000F);
        chk("tlr_mode",  32'(mode),      32'd0);

        // Reset instruction read through DR: IDCODE, or bypass zeros without it
        strobe(1'b0, 1'b0);
        n_cap_clk = 0; n_shf_clk = 0; n_upd = 0;
        rti_to_shf_dr();
        for (int i = 0; i < 32; i++) begin
            strobe_rd(i == 31, 1'b0, o);
            word[i] = o;
        end
        chk("idcode_word", word, IDC_EN ? 32'h1234_5677 : 32'h0000_0000);
        chk("idcode_no_clk_dr", 32'(n_cap_clk + n_shf_clk), 32'd0);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);

        // EXTEST: IR capture pattern and mode one cycle after UPD_IR
        load_ir(4'b0000, cap);
        chk("ir_capture", 32'(cap), 32'h0000_0001);
        @(posedge ICLK); #1;
        chk("mode_before_upd", 32'(mode), 32'd0);
        strobe(1'b0, 1'b0);
        @(posedge ICLK); #1;
        chk("mode_after_upd", 32'(mode), 32'd1);
        chk("upd_to_rti", 32'(tap_state), 32'h0000_000C);

        // SAMPLE through the 8-cell chain
        load_ir(4'b0001, cap);
        strobe(1'b0, 1'b0);
        n_cap_clk = 0; n_shf_clk = 0; n_upd = 0;
        rti_to_shf_dr();
        for (int i = 0; i < 8; i++) strobe(i == 7, 1'($urandom));
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        chk("sample_cap_clk", 32'(n_cap_clk), 32'd1);
        chk("sample_shf_clk", 32'(n_shf_clk), 32'd8);
        chk("sample_upd",     32'(n_upd),     32'd1);
        chk("sample_mode",    32'(mode),      32'd0);

        // BYPASS with the all-ones code and with an undefined code
        byp_ops[0] = 4'b1111;
        byp_ops[1] = 4'b0101;
        for (int k = 0; k < 2; k++) begin
            load_ir(byp_ops[k], cap);
            strobe(1'b0, 1'b0);
            rti_to_shf_dr();
            strobe_rd(1'b0, 1'b1, bout[0]);
            strobe_rd(1'b0, 1'b0, bout[1]);
            strobe_rd(1'b0, 1'b1, bout[2]);
            strobe_rd(1'b0, 1'b1, bout[3]);
            strobe_rd(1'b0, 1'b0, bout[4]);
            chk("bypass_seq", 32'(bout), 32'h0000_001A);
            strobe(1'b1, 1'b0);
            strobe(1'b1, 1'b0);
            strobe(1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of an EXTEST shift
        load_ir(4'b0000, cap);
        strobe(1'b0, 1'b0);
        rti_to_shf_dr();
        strobe(1'b0, 1'b1);
        strobe(1'b0, 1'b0);
        rst_cyc(1'b1, 1'b1);
        chk("arst_state",  32'(tap_state), 32'h0000_000F);
        chk("arst_upd",    32'(update_dr), 32'd0);
        chk("arst_clk_dr", 32'(clk_dr),    32'd0);
        chk("arst_shift",  32'(shift_dr),  32'd0);
        chk("arst_mode",   32'(mode),      32'd0);
        chk("arst_tdo",    32'(TDO),       32'd0);
        chk("arst_oe",     32'(tdo_oe),    32'd0);
        cyc(1'b0, 1'b0, 1'b0);

        // Random walk with occasional resets
        repeat (4000) begin
            if ($urandom_range(0, 299) == 0) rst_cyc(1'($urandom), 1'($urandom));
            else cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
